// File: rtl/cpu_regfile_write_arbiter_pkg.sv
// Shared widths and writeback port identifiers for the register-file write arbiter.
package cpu_regfile_write_arbiter_pkg;
   localparam int   XLEN         = 32;
   localparam int   REG_ADDR_W   = 5;
   localparam int   NUM_REGS     = 32;
   localparam logic WB_PORT_PIPE = 1'b0;
   localparam logic WB_PORT_LONG = 1'b1;
endpackage

// File: rtl/cpu_regfile_write_arbiter_scoreboard.sv
// Busy vector for destinations with an outstanding long-latency write, plus decode lookups.
module cpu_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_valid_i,
   input  logic [REG_ADDR_W-1:0] set_rd_i,
   output logic                  set_ready_o,
   input  logic                  clr_valid_i,
   input  logic [REG_ADDR_W-1:0] clr_rd_i,
   input  logic [REG_ADDR_W-1:0] chk_rd_i,
   output logic                  chk_busy_o,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o
);
   logic [NUM_REGS-1:0] busy_q, busy_d;

   assign set_ready_o = !busy_q[set_rd_i] || (set_rd_i == '0);
   assign chk_busy_o  = busy_q[chk_rd_i] && (chk_rd_i != '0);
   assign rs1_busy_o  = busy_q[rs1_addr_i] && (rs1_addr_i != '0);
   assign rs2_busy_o  = busy_q[rs2_addr_i] && (rs2_addr_i != '0);

   // A set never targets a register being cleared: that register is still busy, so set_ready is low.
   always_comb begin
      busy_d = busy_q;
      if (clr_valid_i) busy_d[clr_rd_i] = 1'b0;
      if (set_valid_i && set_ready_o && (set_rd_i != '0)) busy_d[set_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end
endmodule

// File: rtl/cpu_regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between pipeline and long-latency writeback.
module cpu_regfile_write_arbiter #(
   parameter int XLEN       = cpu_regfile_write_arbiter_pkg::XLEN,
   parameter int REG_ADDR_W = cpu_regfile_write_arbiter_pkg::REG_ADDR_W,
   parameter int NUM_REGS   = cpu_regfile_write_arbiter_pkg::NUM_REGS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [REG_ADDR_W-1:0] req0_rd,
   input  logic [XLEN-1:0]       req0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [REG_ADDR_W-1:0] req1_rd,
   input  logic [XLEN-1:0]       req1_data,
   input  logic                  sb_set_valid,
   input  logic [REG_ADDR_W-1:0] sb_set_rd,
   output logic                  sb_set_ready,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  we3,
   output logic [REG_ADDR_W-1:0] a3,
   output logic [XLEN-1:0]       wd3
);
   import cpu_regfile_write_arbiter_pkg::*;

   logic                  we3_q, wb_from1_q, rr_prio_q;
   logic [REG_ADDR_W-1:0] a3_q;
   logic [XLEN-1:0]       wd3_q;
   logic                  rd0_busy, elig0, elig1, grant0, grant1;

   cpu_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_REGS   (NUM_REGS)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_valid_i (sb_set_valid),
      .set_rd_i    (sb_set_rd),
      .set_ready_o (sb_set_ready),
      .clr_valid_i (we3_q && wb_from1_q),
      .clr_rd_i    (a3_q),
      .chk_rd_i    (req0_rd),
      .chk_busy_o  (rd0_busy),
      .rs1_addr_i  (rs1_addr),
      .rs2_addr_i  (rs2_addr),
      .rs1_busy_o  (rs1_busy),
      .rs2_busy_o  (rs2_busy)
   );

   // Pipeline writes wait behind a pending long write to the same rd to keep WAW order.
   assign elig0 = req0_valid && !rd0_busy;
   assign elig1 = req1_valid;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (elig0 && elig1) begin
         if (rr_prio_q == WB_PORT_PIPE) grant0 = 1'b1;
         else                           grant1 = 1'b1;
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3_q      <= 1'b0;
         a3_q       <= '0;
         wd3_q      <= '0;
         wb_from1_q <= 1'b0;
         rr_prio_q  <= WB_PORT_PIPE;
      end else if (grant0) begin
         we3_q      <= (req0_rd != '0);
         a3_q       <= req0_rd;
         wd3_q      <= req0_data;
         wb_from1_q <= 1'b0;
         rr_prio_q  <= WB_PORT_LONG;
      end else if (grant1) begin
         we3_q      <= (req1_rd != '0);
         a3_q       <= req1_rd;
         wd3_q      <= req1_data;
         wb_from1_q <= 1'b1;
         rr_prio_q  <= WB_PORT_PIPE;
      end else begin
         we3_q      <= 1'b0;
         wb_from1_q <= 1'b0;
      end
   end

   assign we3 = we3_q;
   assign a3  = a3_q;
   assign wd3 = wd3_q;
endmodule
